corelet_ostage: RTL

- Parametrised output stage placed between the MAC-array south outputs and the corelet output bus.
- Replaces the fixed ofifo + sfu_row path with three pieces:
  - per-column rising-edge capture into FIFOs of configurable depth;
  - row-aligned pop;
  - WS-mode kij accumulation buffer with ReLU drain, or OS-mode bypass.
- Adds backpressure on the output, an overflow flag and an explicit accumulation FSM.

---
 rtl/corelet_ostage_if.sv | 24 ++
 rtl/corelet_ostage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/corelet_ostage_if.sv
// Data and handshake bundle between the MAC array south edge,
// corelet_ostage and the corelet output bus.
interface corelet_ostage_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);
    logic [col-1:0]         in_valid;
    logic [col*psum_bw-1:0] in;
    logic                   out_ready;
    logic [col*psum_bw-1:0] out;
    logic                   out_valid;
    logic                   o_full;
    logic                   o_ready;

    modport master (
        output in_valid, in, out_ready,
        input  out, out_valid, o_full, o_ready
    );

    modport slave (
        input  in_valid, in, out_ready,
        output out, out_valid, o_full, o_ready
    );
endinterface

// File: rtl/corelet_ostage.sv
// Output stage: edge-captured column FIFOs, row pop, WS kij accumulate with
// ReLU drain or OS bypass. OSTAGE_SAT_EN selects saturating accumulation.
module corelet_ostage #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16,
    parameter int kij_len = 9,
    parameter int nij_len = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            os,
    input  logic            acc_start,
    corelet_ostage_if.slave bus,
    output logic            busy,
    output logic            done,
    output logic            err_ovf
);
    localparam int W  = col * psum_bw;
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam int NW = (nij_len > 1) ? $clog2(nij_len) : 1;
    localparam int KW = (kij_len > 1) ? $clog2(kij_len) : 1;
    localparam logic [NW-1:0] LAST_N = NW'(nij_len - 1);
    localparam logic [KW-1:0] LAST_K = KW'(kij_len - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t state;

    logic [psum_bw-1:0] mem [col][depth];
    logic [AW-1:0]      wp  [col];
    logic [AW-1:0]      rp  [col];
    logic [CW-1:0]      cnt [col];
    logic [W-1:0]       acc [nij_len];

    logic [col-1:0] last_valid;
    logic [col-1:0] wr;
    logic [col-1:0] wr_ok;
    logic [col-1:0] nempty;
    logic [col-1:0] full;
    logic           take;
    logic           pop;

    logic [NW-1:0] nij_cnt;
    logic [NW-1:0] drain_idx;
    logic [NW-1:0] nxt_idx;
    logic [KW-1:0] kij_cnt;

    logic [W-1:0] row;
    logic [W-1:0] acc_nxt;
    logic [W-1:0] cur_relu;
    logic [W-1:0] nxt_relu;

    function automatic logic [psum_bw-1:0] add_f(
        input logic [psum_bw-1:0] a,
        input logic [psum_bw-1:0] b
    );
`ifdef OSTAGE_SAT_EN
        logic [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (s[psum_bw] != s[psum_bw-1])
            return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                              : {1'b0, {(psum_bw-1){1'b1}}};
        return s[psum_bw-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [psum_bw-1:0] relu_f(
        input logic [psum_bw-1:0] v
    );
        return v[psum_bw-1] ? '0 : v;
    endfunction

    always_comb begin
        row      = '0;
        acc_nxt  = '0;
        cur_relu = '0;
        nxt_relu = '0;
        nxt_idx  = drain_idx + 1'b1;
        for (int c = 0; c < col; c++) begin
            nempty[c] = (cnt[c] != '0);
            full[c]   = (cnt[c] == CW'(depth));
            row[c*psum_bw +: psum_bw] = mem[c][rp[c]];
            acc_nxt[c*psum_bw +: psum_bw] = (kij_cnt == '0)
                ? row[c*psum_bw +: psum_bw]
                : add_f(acc[nij_cnt][c*psum_bw +: psum_bw],
                        row[c*psum_bw +: psum_bw]);
            cur_relu[c*psum_bw +: psum_bw] =
                relu_f(acc[drain_idx][c*psum_bw +: psum_bw]);
            nxt_relu[c*psum_bw +: psum_bw] =
                relu_f(acc[nxt_idx][c*psum_bw +: psum_bw]);
        end
    end

    assign wr    = bus.in_valid & ~last_valid;
    assign take  = os ? (!bus.out_valid || bus.out_ready)
                      : (state == ACCUM);
    assign pop   = (&nempty) && take;
    // a full column still accepts when its head leaves this cycle
    assign wr_ok = wr & (~full | {col{pop}});

    assign bus.o_full  = |full;
    assign bus.o_ready = ~|full;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                wp[c]  <= '0;
                rp[c]  <= '0;
                cnt[c] <= '0;
            end
            last_valid <= '0;
            err_ovf    <= 1'b0;
        end else begin
            last_valid <= bus.in_valid;
            if (|(wr & ~wr_ok))
                err_ovf <= 1'b1;
            for (int c = 0; c < col; c++) begin
                if (wr_ok[c])
                    wp[c] <= wp[c] + 1'b1;
                if (pop)
                    rp[c] <= rp[c] + 1'b1;
                cnt[c] <= cnt[c] + CW'(wr_ok[c]) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++)
            if (wr_ok[c])
                mem[c][wp[c]] <= bus.in[c*psum_bw +: psum_bw];
    end

    always_ff @(posedge clk) begin
        if (!os && pop)
            acc[nij_cnt] <= acc_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            nij_cnt       <= '0;
            kij_cnt       <= '0;
            drain_idx     <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (os) begin
                if (pop) begin
                    bus.out       <= row;
                    bus.out_valid <= 1'b1;
                end else if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (acc_start) begin
                            state   <= ACCUM;
                            nij_cnt <= '0;
                            kij_cnt <= '0;
                        end
                    end
                    ACCUM: begin
                        if (pop) begin
                            if (nij_cnt == LAST_N) begin
                                nij_cnt <= '0;
                                if (kij_cnt == LAST_K) begin
                                    state         <= DRAIN;
                                    drain_idx     <= '0;
                                    bus.out_valid <= 1'b0;
                                end else begin
                                    kij_cnt <= kij_cnt + 1'b1;
                                end
                            end else begin
                                nij_cnt <= nij_cnt + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (!bus.out_valid) begin
                            bus.out       <= cur_relu;
                            bus.out_valid <= 1'b1;
                        end else if (bus.out_ready) begin
                            if (drain_idx == LAST_N) begin
                                state         <= IDLE;
                                bus.out_valid <= 1'b0;
                                done          <= 1'b1;
                            end else begin
                                drain_idx <= nxt_idx;
                                bus.out   <= nxt_relu;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
